// File: rtl/hub75_scan_driver.sv
// HUB75 1/16-scan driver: snapshots the frame map at each frame boundary and scans it
// out two row-lanes at a time (row r on lane 0, row r+ROWS/2 on lane 1).

module hub75_lane_pick #(
  parameter int COLS  = 64,
  parameter int ROWS  = 32,
  parameter int ROW_W = 5,
  parameter int COL_W = 6
) (
  input  logic [COLS*ROWS*3-1:0] frame_i,
  input  logic [ROW_W-1:0]       row_i,
  input  logic [COL_W-1:0]       col_i,
  output logic [2:0]             rgb_o
);
  localparam int IDX_W = $clog2(COLS*ROWS*3);

  logic [31:0]      pix;
  logic [IDX_W-1:0] base;

  assign pix   = 32'(row_i) * 32'(COLS) + 32'(col_i);
  assign base  = IDX_W'(pix * 32'd3);
  assign rgb_o = frame_i[base +: 3];
endmodule

module hub75_scan_driver #(
  parameter int DISPLAY_CYCLES = 256,
  parameter int COLS           = 64,
  parameter int ROWS           = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [COLS*ROWS*3-1:0] frame_in,
  output logic                   r1,
  output logic                   g1,
  output logic                   b1,
  output logic                   r2,
  output logic                   g2,
  output logic                   b2,
  output logic [3:0]             row_addr,
  output logic                   sclk,
  output logic                   lat,
  output logic                   oe_n,
  output logic                   frame_done
);
  localparam int NUM_LANES = 2;
  localparam int SCAN      = ROWS / 2;
  localparam int ROW_W     = $clog2(SCAN);
  localparam int COL_W     = $clog2(COLS);
  localparam int DISP_W    = $clog2(DISPLAY_CYCLES + 1);
  localparam int FRAME_W   = COLS * ROWS * 3;

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(SCAN - 1);
  localparam logic [COL_W-1:0]  COL_FIRST = COL_W'(COLS - 1);
  localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISPLAY_CYCLES - 1);

  typedef enum logic [2:0] {
    LOAD, SHIFT, BLANK, LATCH, ADDR, DISPLAY
  } state_e;

  state_e               state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic                 phase_q, phase_d;
  logic [DISP_W-1:0]    disp_q, disp_d;
  logic [FRAME_W-1:0]   shadow_q, shadow_d;

  logic [NUM_LANES-1:0][2:0] lane_rgb;
  logic [NUM_LANES-1:0][2:0] rgb_q, rgb_d;
  logic [3:0]                row_addr_q, row_addr_d;
  logic                      sclk_q, sclk_d;
  logic                      lat_q, lat_d;
  logic                      oe_n_q, oe_n_d;
  logic                      fdone_q, fdone_d;

  // Lanes look at the next-cycle shadow/row/col so colour data lands with its phase-A cycle.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    hub75_lane_pick #(
      .COLS (COLS),
      .ROWS (ROWS),
      .ROW_W(ROW_W + 1),
      .COL_W(COL_W)
    ) u_pick (
      .frame_i(shadow_d),
      .row_i  ({1'(l), row_d}),
      .col_i  (col_d),
      .rgb_o  (lane_rgb[l])
    );
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    phase_d  = phase_q;
    disp_d   = disp_q;
    shadow_d = shadow_q;
    case (state_q)
      LOAD: begin
        if (enable) begin
          state_d  = SHIFT;
          shadow_d = frame_in;
          row_d    = '0;
          col_d    = COL_FIRST;
          phase_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (col_q == '0) begin
          state_d = BLANK;
          phase_d = 1'b0;
        end else begin
          col_d   = col_q - 1'b1;
          phase_d = 1'b0;
        end
      end
      BLANK: state_d = LATCH;
      LATCH: state_d = ADDR;
      ADDR: begin
        state_d = DISPLAY;
        disp_d  = '0;
      end
      DISPLAY: begin
        if (disp_q == DISP_LAST) begin
          col_d   = COL_FIRST;
          phase_d = 1'b0;
          if (row_q == ROW_LAST) begin
            state_d = LOAD;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = SHIFT;
          end
        end else begin
          disp_d = disp_q + 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Pin values are registered from the next state so they line up with state_q, glitch-free.
  always_comb begin
    sclk_d     = (state_d == SHIFT) && phase_d;
    lat_d      = (state_d == LATCH);
    oe_n_d     = (state_d != DISPLAY);
    row_addr_d = (state_d == ADDR) ? 4'(row_d) : row_addr_q;
    fdone_d    = (state_d == DISPLAY) && (disp_d == DISP_LAST) && (row_d == ROW_LAST);
    rgb_d      = ((state_d == SHIFT) && !phase_d) ? lane_rgb : rgb_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LOAD;
      row_q      <= '0;
      col_q      <= COL_FIRST;
      phase_q    <= 1'b0;
      disp_q     <= '0;
      shadow_q   <= '0;
      rgb_q      <= '0;
      row_addr_q <= '0;
      sclk_q     <= 1'b0;
      lat_q      <= 1'b0;
      oe_n_q     <= 1'b1;
      fdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      phase_q    <= phase_d;
      disp_q     <= disp_d;
      shadow_q   <= shadow_d;
      rgb_q      <= rgb_d;
      row_addr_q <= row_addr_d;
      sclk_q     <= sclk_d;
      lat_q      <= lat_d;
      oe_n_q     <= oe_n_d;
      fdone_q    <= fdone_d;
    end
  end

  assign {r1, g1, b1} = rgb_q[0];
  assign {r2, g2, b2} = rgb_q[1];
  assign row_addr     = row_addr_q;
  assign sclk         = sclk_q;
  assign lat          = lat_q;
  assign oe_n         = oe_n_q;
  assign frame_done   = fdone_q;
endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver with DISPLAY_CYCLES=8 (row 139, frame 2225 cycles).

module tb_hub75_scan_driver;
  localparam int DC     = 8;
  localparam int ROWP   = 139;
  localparam int FRAMEP = 2225;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [6143:0] frame_in = '0;
  logic          r1, g1, b1, r2, g2, b2;
  logic [3:0]    row_addr;
  logic          sclk, lat, oe_n, frame_done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  wire [5:0] col6 = {r1, g1, b1, r2, g2, b2};

  always #5 clk = ~clk;

  hub75_scan_driver #(.DISPLAY_CYCLES(DC), .COLS(64), .ROWS(32)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_in(frame_in),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .row_addr(row_addr), .sclk(sclk), .lat(lat), .oe_n(oe_n), .frame_done(frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // After this returns, the DUT sits in LOAD at cyc 0; cyc 1 is row 0's first phase-A cycle.
  task automatic restart(input logic [6143:0] f);
    rst = 1'b0;
    enable = 1'b1;
    frame_in = f;
    step();
    step();
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    logic [6143:0] f;
    int n;
    rst = 1'b0; enable = 1'b0; frame_in = '0;
    step();
    checks++;
    if (oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n: got %b want 1", oe_n); end
    checks++;
    if ({lat, sclk, frame_done, row_addr, col6} !== 13'b0) begin
      errors++; $display("FAIL reset_outs: got %b want 0", {lat, sclk, frame_done, row_addr, col6});
    end
    f = '1;
    restart(f);
    repeat (4) step();
    checks++;
    if ({sclk, col6} !== 7'b1111111) begin
      errors++; $display("FAIL pre_reset_shift: got %b want 1111111", {sclk, col6});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({oe_n, lat, sclk, row_addr, col6} !== 13'b1_0000000000_00) begin
      errors++; $display("FAIL midshift_reset: got %b want 1000000000000", {oe_n, lat, sclk, row_addr, col6});
    end
    rst = 1'b1; enable = 1'b1;
    n = 0;
    while (n < 10) begin
      step();
      n++;
      if (sclk) break;
    end
    checks++;
    if (n !== 2) begin errors++; $display("FAIL first_sclk_latency: got %0d want 2", n); end
  endtask

  task automatic test_white_pixel();
    logic [6143:0] f;
    logic [5:0] exp;
    f = '0;
    f[191] = 1'b1; f[190] = 1'b1; f[189] = 1'b1;
    restart(f);
    for (int k = 1; k <= 128; k++) begin
      step();
      exp = (k <= 2) ? 6'b111000 : 6'b000000;
      checks++;
      if (col6 !== exp) begin errors++; $display("FAIL white_px k=%0d: got %b want %b", k, col6, exp); end
      checks++;
      if (sclk !== ((k % 2) == 0)) begin errors++; $display("FAIL white_sclk k=%0d: got %b want %b", k, sclk, (k % 2) == 0); end
    end
  endtask

  task automatic test_red_lower();
    logic [6143:0] f;
    logic [5:0] exp;
    f = '0;
    f[3074] = 1'b1;
    restart(f);
    for (int k = 1; k <= 128; k++) begin
      step();
      exp = (k >= 127) ? 6'b000100 : 6'b000000;
      checks++;
      if (col6 !== exp) begin errors++; $display("FAIL red_lower k=%0d: got %b want %b", k, col6, exp); end
    end
  endtask

  task automatic test_free_run();
    logic [6143:0] f;
    int rises, lat_hi, oe_lo, exp_row, rows_done, fd_cnt;
    logic prev_sclk, prev_oe;
    f = '0;
    for (int i = 0; i < 6144; i += 7) f[i] = 1'b1;
    restart(f);
    rises = 0; lat_hi = 0; oe_lo = 0; exp_row = 0; rows_done = 0; fd_cnt = 0;
    prev_sclk = 1'b0; prev_oe = 1'b1;
    for (int c = 1; c <= 2 * FRAMEP + 2; c++) begin
      step();
      if (sclk && !prev_sclk) rises++;
      if (lat) lat_hi++;
      if (!oe_n) oe_lo++;
      if (oe_n && !prev_oe) begin
        checks++;
        if (rises !== 64) begin errors++; $display("FAIL row%0d_sclk_rises: got %0d want 64", rows_done, rises); end
        checks++;
        if (lat_hi !== 1) begin errors++; $display("FAIL row%0d_lat: got %0d want 1", rows_done, lat_hi); end
        checks++;
        if (oe_lo !== DC) begin errors++; $display("FAIL row%0d_oe_low: got %0d want %0d", rows_done, oe_lo, DC); end
        checks++;
        if (row_addr !== 4'(exp_row)) begin errors++; $display("FAIL row%0d_addr: got %0d want %0d", rows_done, row_addr, exp_row); end
        rows_done++;
        exp_row = (exp_row + 1) % 16;
        rises = 0; lat_hi = 0; oe_lo = 0;
      end
      if (frame_done) begin
        checks++;
        if (cyc !== FRAMEP - 1 + fd_cnt * FRAMEP) begin
          errors++; $display("FAIL frame_done_cycle: got %0d want %0d", cyc, FRAMEP - 1 + fd_cnt * FRAMEP);
        end
        fd_cnt++;
      end
      prev_sclk = sclk;
      prev_oe = oe_n;
    end
    checks++;
    if (rows_done !== 32) begin errors++; $display("FAIL rows_completed: got %0d want 32", rows_done); end
    checks++;
    if (fd_cnt !== 2) begin errors++; $display("FAIL frame_done_count: got %0d want 2", fd_cnt); end
  endtask

  task automatic test_mid_frame_change();
    logic [6143:0] fa, fb;
    fa = '0; fa[1342] = 1'b1;
    fb = '0; fb[1341] = 1'b1;
    restart(fa);
    while (cyc < 1 + 5 * ROWP) step();
    frame_in = fb;
    while (cyc < 1 + 6 * ROWP) step();
    checks++;
    if (col6 !== 6'b010000) begin errors++; $display("FAIL old_frame_row6: got %b want 010000", col6); end
    step();
    checks++;
    if (col6 !== 6'b010000) begin errors++; $display("FAIL old_frame_row6_b: got %b want 010000", col6); end
    while (cyc < FRAMEP + 1 + 6 * ROWP) step();
    checks++;
    if (col6 !== 6'b001000) begin errors++; $display("FAIL new_frame_row6: got %b want 001000", col6); end
  endtask

  task automatic test_enable_low();
    logic [6143:0] f;
    f = '0;
    f[191] = 1'b1; f[190] = 1'b1; f[189] = 1'b1;
    restart(f);
    while (cyc < FRAMEP - 1) step();
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done_before_idle: got %b want 1", frame_done); end
    enable = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({oe_n, sclk, lat, frame_done} !== 4'b1000) begin
        errors++; $display("FAIL idle_load i=%0d: got %b want 1000", i, {oe_n, sclk, lat, frame_done});
      end
    end
    checks++;
    if (row_addr !== 4'd15) begin errors++; $display("FAIL idle_row_addr: got %0d want 15", row_addr); end
    enable = 1'b1;
    step();
    checks++;
    if ({sclk, col6} !== 7'b0111000) begin errors++; $display("FAIL resume_first_col: got %b want 0111000", {sclk, col6}); end
    step();
    checks++;
    if (sclk !== 1'b1) begin errors++; $display("FAIL resume_sclk: got %b want 1", sclk); end
    repeat (129) step();
    checks++;
    if ({row_addr, oe_n, lat} !== 6'b0000_1_0) begin errors++; $display("FAIL resume_addr: got %b want 000010", {row_addr, oe_n, lat}); end
    step();
    checks++;
    if (oe_n !== 1'b0) begin errors++; $display("FAIL resume_display: got %b want 0", oe_n); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_white_pixel();
    test_red_lower();
    test_free_run();
    test_mid_frame_change();
    test_enable_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hub75_scan_driver.md
Name: hub75_scan_driver

Overview:
Downstream consumer of the scene renderer's 6144-bit frame map (64x32 pixels, 3 bits per pixel). It snapshots one frame at each frame boundary and scans it out to a 64x32, 1/16-scan HUB75 LED panel. Rows r and r+16 are driven together on the two colour lanes. It drives the serial clock, latch, output-enable and row-address pins, and flags frame completion to the top level.

Parameters:
DISPLAY_CYCLES, 256, clk cycles OE is held asserted (low) per row
COLS, 64, pixels per row (fixed; frame_in width is tied to it)
ROWS, 32, panel rows; scan depth is ROWS/2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
enable  input  1  scan enable, sampled only in LOAD
frame_in  input  6144  frame map; pixel p = row*64+col, R=bit 3p+2, G=bit 3p+1, B=bit 3p
r1,g1,b1  output  1 each  colour for upper-half row r
r2,g2,b2  output  1 each  colour for lower-half row r+16
row_addr  output  4  HUB75 A..D, row pair index r
sclk  output  1  panel shift clock
lat  output  1  panel latch, active-high
oe_n  output  1  panel output enable, active-low
frame_done  output  1  one-cycle pulse at end of row 15 display

Behaviour:
- Reset (rst=0, asynchronous): state=LOAD, row=0, col counter=63, sclk=0, lat=0, oe_n=1, row_addr=0, all colour outputs 0, frame_done=0, shadow frame cleared to 0.
- States: LOAD -> SHIFT -> BLANK -> LATCH -> ADDR -> DISPLAY -> (SHIFT or LOAD).
- LOAD (1 cycle):
  - If enable=1: shadow <= frame_in, row <= 0, go to SHIFT.
  - If enable=0: stay in LOAD with oe_n=1.
  - frame_in is sampled only here, so changes mid-frame never tear the image.
- SHIFT (128 cycles, 2 per column):
  - Columns go out from col 63 down to col 0.
  - Phase A: colour outputs take shadow pixels (row, col) and (row+16, col); sclk=0.
  - Phase B: sclk=1, data held stable.
  - After col 0 phase B, go to BLANK with sclk=0.
- BLANK (1 cycle): oe_n=1.
- LATCH (1 cycle): lat=1, oe_n=1.
- ADDR (1 cycle): lat=0, row_addr <= row, oe_n=1.
- DISPLAY (DISPLAY_CYCLES cycles): oe_n=0, then exit.
  - If row=15: frame_done=1 for exactly the exit cycle, then go to LOAD.
  - Otherwise: row <= row+1, go to SHIFT.
- oe_n is 1 in every state except DISPLAY. lat is 1 only in LATCH. sclk toggles only in SHIFT.
- Timing: row period = 128+3+DISPLAY_CYCLES cycles; frame period = 1 + 16*row period.
- enable is ignored outside LOAD; deasserting it mid-frame takes effect at the next LOAD.
- Counters: col is 6-bit down-counting with no wrap (exit on 0); row is 4-bit up-counting; the display counter is wide enough for DISPLAY_CYCLES.
- Reset mid-operation returns all outputs to reset values immediately. The scan restarts at LOAD/row 0 once rst is released.

Test Plan:
(All scenarios use DISPLAY_CYCLES=8: row period 139, frame period 2225.)
1. Reset asserted mid-SHIFT -> same cycle oe_n=1, lat=0, sclk=0, row_addr=0, colours 0. After release and enable=1, the first sclk rise is 2 cycles after LOAD.
2. frame_in with only pixel (row 0, col 63) all-white (bits 191:189=3'b111), enable=1 -> r1=g1=b1=1 only during the first column pair of row 0; r2/g2/b2 stay 0; all other columns 0.
3. Pixel (row 16, col 0) red only (bit 3074=1) -> r2=1 only during the last column pair of row 0; r1=0 throughout.
4. Free-run two frames -> exactly 64 sclk rises and 1 lat pulse per row, oe_n low exactly 8 cycles per row, row_addr steps 0..15. frame_done pulses every 2225 cycles.
5. Change frame_in mid-frame (row 5) -> outputs reflect the old frame until the next LOAD, then the new frame.
6. enable=0 at frame end -> stays in LOAD with oe_n=1 and no sclk. Re-assert enable=1 -> scan resumes at row 0 on the next cycle.
